// File: rtl/aaxi_fifo_bridge.sv
// Request FIFO bridge: queues slave requests toward a master port and returns one
// in-order response per request, bounding accepted-but-unanswered requests.
module aaxi_fifo_bridge #(
   parameter int ADDR_W    = 30,
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 4,
   parameter int MAX_OUTST = 4,
   parameter int STRB_W    = DATA_W / 8,
   parameter int OUTST_W   = $clog2(MAX_OUTST + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                s_avalid,
   output logic                s_aready,
   input  logic                s_awe,
   input  logic [ADDR_W-1:0]   s_aaddr,
   input  logic [DATA_W-1:0]   s_adata,
   input  logic [STRB_W-1:0]   s_astrb,
   output logic                s_bvalid,
   output logic [DATA_W-1:0]   s_bdata,
   output logic                m_avalid,
   input  logic                m_aready,
   output logic                m_awe,
   output logic [ADDR_W-1:0]   m_aaddr,
   output logic [DATA_W-1:0]   m_adata,
   output logic [STRB_W-1:0]   m_astrb,
   input  logic                m_bvalid,
   input  logic [DATA_W-1:0]   m_bdata,
   output logic [OUTST_W-1:0]  outst,
   output logic                err_stray
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int ENT_W = 1 + ADDR_W + DATA_W + STRB_W;

   logic [ENT_W-1:0]   mem_q [DEPTH];
   logic [PTR_W-1:0]   wptr_q, rptr_q;
   logic [CNT_W-1:0]   count_q;
   logic [OUTST_W-1:0] inflight_q;
   logic [OUTST_W-1:0] outst_q;
   logic               s_bvalid_q;
   logic [DATA_W-1:0]  s_bdata_q;
   logic               err_stray_q;

   logic push, pop, resp_ok, stray;

   assign s_aready = (count_q != CNT_W'(DEPTH)) && (outst_q < OUTST_W'(MAX_OUTST));
   assign m_avalid = (count_q != '0);
   assign push     = s_avalid && s_aready;
   assign pop      = m_avalid && m_aready;
   // A response is only legitimate while something is actually in flight downstream.
   assign resp_ok  = m_bvalid && (inflight_q != '0);
   assign stray    = m_bvalid && (inflight_q == '0);

   assign {m_awe, m_aaddr, m_adata, m_astrb} = mem_q[rptr_q];
   assign s_bvalid  = s_bvalid_q;
   assign s_bdata   = s_bdata_q;
   assign outst     = outst_q;
   assign err_stray = err_stray_q;

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= {s_awe, s_aaddr, s_adata, s_astrb};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         inflight_q  <= '0;
         outst_q     <= '0;
         s_bvalid_q  <= 1'b0;
         s_bdata_q   <= '0;
         err_stray_q <= 1'b0;
      end else begin
         if (push) wptr_q <= wptr_q + PTR_W'(1);
         if (pop)  rptr_q <= rptr_q + PTR_W'(1);

         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase

         case ({pop, resp_ok})
            2'b10:   inflight_q <= inflight_q + OUTST_W'(1);
            2'b01:   inflight_q <= inflight_q - OUTST_W'(1);
            default: inflight_q <= inflight_q;
         endcase

         case ({push, s_bvalid_q})
            2'b10:   outst_q <= outst_q + OUTST_W'(1);
            2'b01:   outst_q <= outst_q - OUTST_W'(1);
            default: outst_q <= outst_q;
         endcase

         s_bvalid_q <= resp_ok;
         if (resp_ok) s_bdata_q <= m_bdata;
         if (stray)   err_stray_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_aaxi_fifo_bridge.sv
// Directed bench for aaxi_fifo_bridge: one instance with default sizing and one
// with MAX_OUTST=2 for the outstanding-limit case.
module tb_aaxi_fifo_bridge;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Instance A: DEPTH=4, MAX_OUTST=4
   logic        a_s_avalid, a_s_aready, a_s_awe, a_s_bvalid;
   logic [29:0] a_s_aaddr, a_m_aaddr;
   logic [31:0] a_s_adata, a_s_bdata, a_m_adata, a_m_bdata;
   logic [3:0]  a_s_astrb, a_m_astrb;
   logic        a_m_avalid, a_m_aready, a_m_awe, a_m_bvalid, a_err;
   logic [2:0]  a_outst;

   // Instance B: DEPTH=4, MAX_OUTST=2
   logic        b_s_avalid, b_s_aready, b_s_awe, b_s_bvalid;
   logic [29:0] b_s_aaddr, b_m_aaddr;
   logic [31:0] b_s_adata, b_s_bdata, b_m_adata, b_m_bdata;
   logic [3:0]  b_s_astrb, b_m_astrb;
   logic        b_m_avalid, b_m_aready, b_m_awe, b_m_bvalid, b_err;
   logic [1:0]  b_outst;

   aaxi_fifo_bridge #(.ADDR_W(30), .DATA_W(32), .DEPTH(4), .MAX_OUTST(4)) u_a (
      .clk(clk), .rst_n(rst_n),
      .s_avalid(a_s_avalid), .s_aready(a_s_aready), .s_awe(a_s_awe),
      .s_aaddr(a_s_aaddr), .s_adata(a_s_adata), .s_astrb(a_s_astrb),
      .s_bvalid(a_s_bvalid), .s_bdata(a_s_bdata),
      .m_avalid(a_m_avalid), .m_aready(a_m_aready), .m_awe(a_m_awe),
      .m_aaddr(a_m_aaddr), .m_adata(a_m_adata), .m_astrb(a_m_astrb),
      .m_bvalid(a_m_bvalid), .m_bdata(a_m_bdata),
      .outst(a_outst), .err_stray(a_err)
   );

   aaxi_fifo_bridge #(.ADDR_W(30), .DATA_W(32), .DEPTH(4), .MAX_OUTST(2)) u_b (
      .clk(clk), .rst_n(rst_n),
      .s_avalid(b_s_avalid), .s_aready(b_s_aready), .s_awe(b_s_awe),
      .s_aaddr(b_s_aaddr), .s_adata(b_s_adata), .s_astrb(b_s_astrb),
      .s_bvalid(b_s_bvalid), .s_bdata(b_s_bdata),
      .m_avalid(b_m_avalid), .m_aready(b_m_aready), .m_awe(b_m_awe),
      .m_aaddr(b_m_aaddr), .m_adata(b_m_adata), .m_astrb(b_m_astrb),
      .m_bvalid(b_m_bvalid), .m_bdata(b_m_bdata),
      .outst(b_outst), .err_stray(b_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      a_s_avalid = 0; a_s_awe = 0; a_s_aaddr = '0; a_s_adata = '0; a_s_astrb = '0;
      a_m_aready = 0; a_m_bvalid = 0; a_m_bdata = '0;
      b_s_avalid = 0; b_s_awe = 0; b_s_aaddr = '0; b_s_adata = '0; b_s_astrb = '0;
      b_m_aready = 0; b_m_bvalid = 0; b_m_bdata = '0;

      // Reset state
      #2;
      chk("rst_m_avalid", a_m_avalid, 0);
      chk("rst_s_aready", a_s_aready, 1);
      chk("rst_outst", a_outst, 0);
      chk("rst_err", a_err, 0);
      chk("rst_s_bvalid", a_s_bvalid, 0);
      chk("rst_s_bdata", a_s_bdata, 0);
      tick();
      rst_n = 1;

      // Single write
      a_s_avalid = 1; a_s_awe = 1; a_s_aaddr = 30'd0; a_s_adata = 32'd42; a_s_astrb = 4'hF;
      tick();
      a_s_avalid = 0;
      chk("w1_m_avalid", a_m_avalid, 1);
      chk("w1_m_awe", a_m_awe, 1);
      chk("w1_m_aaddr", a_m_aaddr, 0);
      chk("w1_m_adata", a_m_adata, 42);
      chk("w1_m_astrb", a_m_astrb, 4'hF);
      chk("w1_outst1", a_outst, 1);
      a_m_aready = 1;
      tick();
      a_m_aready = 0;
      chk("w1_popped", a_m_avalid, 0);
      a_m_bvalid = 1; a_m_bdata = 32'd55;
      tick();
      a_m_bvalid = 0;
      chk("w1_s_bvalid", a_s_bvalid, 1);
      chk("w1_s_bdata", a_s_bdata, 55);
      tick();
      chk("w1_s_bvalid_pulse", a_s_bvalid, 0);
      chk("w1_outst0", a_outst, 0);

      // Back-pressure: fill FIFO with 1..4
      for (int i = 1; i <= 4; i++) begin
         chk("bp_ready_before", a_s_aready, 1);
         a_s_avalid = 1; a_s_awe = 1; a_s_aaddr = 30'(i); a_s_adata = 32'(i); a_s_astrb = 4'hF;
         tick();
      end
      a_s_avalid = 0;
      chk("bp_full_ready", a_s_aready, 0);
      chk("bp_outst4", a_outst, 4);
      tick();
      chk("bp_stable_head", a_m_adata, 1);
      a_m_aready = 1;
      for (int i = 1; i <= 4; i++) begin
         chk("bp_order", a_m_adata, 32'(i));
         tick();
      end
      a_m_aready = 0;
      chk("bp_drained", a_m_avalid, 0);
      for (int i = 1; i <= 4; i++) begin
         a_m_bvalid = 1; a_m_bdata = 32'(100 + i);
         tick();
         chk("bp_resp_v", a_s_bvalid, 1);
         chk("bp_resp_d", a_s_bdata, 32'(100 + i));
      end
      a_m_bvalid = 0;
      tick();
      chk("bp_resp_end", a_s_bvalid, 0);
      chk("bp_outst0", a_outst, 0);

      // Simultaneous push/pop and accept/emit
      a_m_aready = 1;
      a_s_avalid = 1; a_s_awe = 0; a_s_aaddr = 30'd5;
      tick();
      a_s_aaddr = 30'd6;
      tick();
      chk("sim_pp_avalid", a_m_avalid, 1);
      chk("sim_pp_head", a_m_aaddr, 6);
      chk("sim_pp_outst", a_outst, 2);
      a_s_avalid = 0;
      tick();
      chk("sim_pp_empty", a_m_avalid, 0);
      a_m_aready = 0;
      a_m_bvalid = 1; a_m_bdata = 32'd7;
      tick();
      chk("sim_resp_v", a_s_bvalid, 1);
      chk("sim_resp_outst", a_outst, 2);
      a_m_bvalid = 0;
      a_s_avalid = 1; a_s_aaddr = 30'd9;
      tick();
      a_s_avalid = 0;
      chk("sim_acc_emit_outst", a_outst, 2);
      chk("sim_acc_head", a_m_aaddr, 9);
      a_m_aready = 1;
      tick();
      a_m_aready = 0;
      a_m_bvalid = 1; a_m_bdata = 32'd11;
      tick();
      a_m_bdata = 32'd12;
      tick();
      chk("sim_last_d", a_s_bdata, 12);
      a_m_bvalid = 0;
      tick();
      chk("sim_outst0", a_outst, 0);

      // Stray response
      a_m_bvalid = 1; a_m_bdata = 32'hDEAD;
      tick();
      a_m_bvalid = 0;
      chk("stray_no_bvalid", a_s_bvalid, 0);
      chk("stray_err", a_err, 1);
      tick(); tick();
      chk("stray_sticky", a_err, 1);
      chk("stray_outst", a_outst, 0);

      // Outstanding limit (instance B)
      b_m_aready = 1;
      b_s_avalid = 1; b_s_awe = 0; b_s_aaddr = 30'd1;
      tick();
      b_s_aaddr = 30'd2;
      tick();
      chk("lim_ready0", b_s_aready, 0);
      chk("lim_outst2", b_outst, 2);
      b_s_aaddr = 30'd3;
      tick();
      chk("lim_still_blocked", b_s_aready, 0);
      b_m_bvalid = 1; b_m_bdata = 32'd9;
      tick();
      b_m_bvalid = 0;
      chk("lim_bvalid", b_s_bvalid, 1);
      chk("lim_ready_at_bvalid", b_s_aready, 0);
      tick();
      chk("lim_ready_after", b_s_aready, 1);
      chk("lim_outst1", b_outst, 1);
      tick();
      b_s_avalid = 0;
      chk("lim_third_accept", b_outst, 2);

      // Reset mid-operation with 3 queued requests
      a_m_aready = 0;
      for (int i = 0; i < 3; i++) begin
         a_s_avalid = 1; a_s_awe = 1; a_s_aaddr = 30'(20 + i); a_s_adata = 32'(i);
         tick();
      end
      a_s_avalid = 0;
      chk("mid_queued", a_m_avalid, 1);
      chk("mid_outst3", a_outst, 3);
      rst_n = 0;
      #1;
      chk("mid_rst_avalid", a_m_avalid, 0);
      chk("mid_rst_outst", a_outst, 0);
      chk("mid_rst_ready", a_s_aready, 1);
      chk("mid_rst_err", a_err, 0);
      tick();
      rst_n = 1;
      a_s_avalid = 1; a_s_aaddr = 30'd40;
      a_m_bvalid = 1; a_m_bdata = 32'd77;
      tick();
      a_s_avalid = 0; a_m_bvalid = 0;
      chk("post_first_accept", a_outst, 1);
      chk("post_stray_err", a_err, 1);
      chk("post_no_bvalid", a_s_bvalid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
